// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: RAM status, grant FSM states, data words.
// Pure declarations; no latency and no backpressure of its own.
package cache_mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one single-port RAM between icache and dcache with dcache priority and bounded icache starvation.
// Latency: at least 2 cycles from request to wait low; one IDLE bubble between grants; RAM stalls via ramstate.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             ram_err_q, ram_err_d;
    ramstate_t        rs;
    logic             dreq;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign ram_err = ram_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ram_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ram_err_q    <= ram_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ram_err_d    = ram_err_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_q)
            IDLE: begin
                // dcache wins unless icache has already lost STARVE_MAX times in a row
                if (dreq && (starve_cnt_q < CNT_MAX || !iREN)) begin
                    state_d = DGRANT;
                    if (iREN && starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (iREN) begin
                    state_d      = IGRANT;
                    starve_cnt_d = '0;
                end
            end

            DGRANT: begin
                // simultaneous dREN/dWEN is treated as a write
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (rs == ERROR) begin
                    ram_err_d = 1'b1;
                end
                if (!dreq) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (rs == ERROR) begin
                    ram_err_d = 1'b1;
                end
                if (!iREN) begin
                    state_d = IDLE;
                end else if (rs == ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
